// File: rtl/alu_flag_register_pkg.sv
// Shared constants for the ALU status-flag register and its branch-condition evaluator.
// Flag bit positions follow the {OV,S,CY,Z} ordering of the flags bus.
package alu_flag_register_pkg;

    localparam int unsigned DATA_W_DEFAULT = 16;
    localparam int unsigned COND_W_DEFAULT = 4;

    localparam int unsigned FLAG_Z  = 0;
    localparam int unsigned FLAG_CY = 1;
    localparam int unsigned FLAG_S  = 2;
    localparam int unsigned FLAG_OV = 3;

    typedef enum logic [3:0] {
        COND_ALWAYS = 4'd0,
        COND_GE     = 4'd1,
        COND_LT     = 4'd2,
        COND_NE     = 4'd3,
        COND_EQ     = 4'd4,
        COND_PL     = 4'd5,
        COND_MI     = 4'd6,
        COND_CC     = 4'd7,
        COND_CS     = 4'd8,
        COND_VC     = 4'd9,
        COND_VS     = 4'd10
    } cond_e;

endpackage

// File: rtl/alu_branch_cond_eval.sv
// Combinational branch-condition evaluator: {OV,S,CY,Z} flags + condition code -> taken.
// Also used by the decoder for static prediction; reserved codes never take.
module alu_branch_cond_eval
    import alu_flag_register_pkg::*;
#(
    parameter int unsigned COND_W = COND_W_DEFAULT
) (
    input  logic [3:0]        i_flags,
    input  logic [COND_W-1:0] i_cond_sel,
    output logic              o_taken
);

    logic w_z, w_cy, w_s, w_ov;

    assign w_z  = i_flags[FLAG_Z];
    assign w_cy = i_flags[FLAG_CY];
    assign w_s  = i_flags[FLAG_S];
    assign w_ov = i_flags[FLAG_OV];

    always_comb begin
        o_taken = 1'b0;
        case (i_cond_sel)
            COND_W'(COND_ALWAYS): o_taken = 1'b1;
            COND_W'(COND_GE):     o_taken = (w_s == w_ov);
            COND_W'(COND_LT):     o_taken = (w_s != w_ov);
            COND_W'(COND_NE):     o_taken = ~w_z;
            COND_W'(COND_EQ):     o_taken = w_z;
            COND_W'(COND_PL):     o_taken = ~w_s;
            COND_W'(COND_MI):     o_taken = w_s;
            COND_W'(COND_CC):     o_taken = ~w_cy;
            COND_W'(COND_CS):     o_taken = w_cy;
            COND_W'(COND_VC):     o_taken = ~w_ov;
            COND_W'(COND_VS):     o_taken = w_ov;
            default:              o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flag_register.sv
// ALU status-flag register (Z/CY/S/OV), adder carry-in generation and registered branch evaluation.
// Optional sticky overflow flag is built when ALU_FLAG_STICKY_OV_EN is defined.
module alu_flag_register
    import alu_flag_register_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned COND_W = COND_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_z,
    input  logic              alu_cy,
    input  logic              alu_ov,
    input  logic              alu_valid,
    input  logic [3:0]        upd_mask,
    input  logic              use_carry,
    input  logic              add_sub_sel,
    input  logic              flag_load,
    input  logic [3:0]        flag_wdata,
    input  logic              eval,
    input  logic [COND_W-1:0] cond_sel,
`ifdef ALU_FLAG_STICKY_OV_EN
    input  logic              sticky_clr,
    output logic              sticky_ov,
`endif
    output logic              carry_in,
    output logic [3:0]        flags,
    output logic              branch_taken,
    output logic              branch_valid
);

    typedef enum logic {
        ST_IDLE,
        ST_RESULT
    } eval_state_e;

    logic [3:0]  r_flags;
    logic [3:0]  w_flags_nxt;
    eval_state_e r_state;
    eval_state_e w_state_nxt;
    logic        r_taken;
    logic        w_taken_nxt;
    logic        w_cond_taken;

    // SBC borrows when CY=1 because the subtract carry-in is inverted by the stored carry.
    assign carry_in = add_sub_sel ^ (use_carry & r_flags[FLAG_CY]);

    always_comb begin
        w_flags_nxt = r_flags;
        if (flag_load) begin
            w_flags_nxt = flag_wdata;
        end else if (alu_valid) begin
            if (upd_mask[FLAG_Z])  w_flags_nxt[FLAG_Z]  = (alu_z == '0);
            if (upd_mask[FLAG_CY]) w_flags_nxt[FLAG_CY] = alu_cy;
            if (upd_mask[FLAG_S])  w_flags_nxt[FLAG_S]  = alu_z[DATA_W-1];
            if (upd_mask[FLAG_OV]) w_flags_nxt[FLAG_OV] = alu_ov;
        end
    end

    // Evaluate against the flags being written this cycle so a branch never sees stale state.
    alu_branch_cond_eval #(
        .COND_W (COND_W)
    ) u_cond_eval (
        .i_flags    (w_flags_nxt),
        .i_cond_sel (cond_sel),
        .o_taken    (w_cond_taken)
    );

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_taken_nxt = 1'b0;
        if (eval) begin
            w_state_nxt = ST_RESULT;
            w_taken_nxt = w_cond_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
            r_state <= ST_IDLE;
            r_taken <= 1'b0;
        end else begin
            r_flags <= w_flags_nxt;
            r_state <= w_state_nxt;
            r_taken <= w_taken_nxt;
        end
    end

    assign flags        = r_flags;
    assign branch_valid = (r_state == ST_RESULT);
    assign branch_taken = r_taken;

`ifdef ALU_FLAG_STICKY_OV_EN
    logic r_sticky_ov;
    logic w_ov_set;

    assign w_ov_set = flag_load ? flag_wdata[FLAG_OV]
                                : (alu_valid & upd_mask[FLAG_OV] & alu_ov);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky_ov <= 1'b0;
        end else if (w_ov_set) begin
            r_sticky_ov <= 1'b1;
        end else if (sticky_clr) begin
            r_sticky_ov <= 1'b0;
        end
    end

    assign sticky_ov = r_sticky_ov;
`endif

endmodule

// File: tb/tb_alu_flag_register.sv
// Table-driven scoreboard bench for alu_flag_register; sticky-OV sequence runs when
// ALU_FLAG_STICKY_OV_EN is defined.
module tb_alu_flag_register;
    import alu_flag_register_pkg::*;

    typedef struct {
        logic        rst;
        logic [15:0] z;
        logic        cy;
        logic        ov;
        logic        valid;
        logic [3:0]  mask;
        logic        uc;
        logic        sub;
        logic        load;
        logic [3:0]  wdata;
        logic        ev;
        logic [3:0]  cond;
        logic        exp_cin;
        logic [3:0]  exp_flags;
        logic        exp_bv;
        logic        exp_bt;
    } vec_t;

    typedef struct {
        int unsigned idx;
        logic [3:0]  flags;
        logic        bv;
        logic        bt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] alu_z;
    logic        alu_cy, alu_ov, alu_valid;
    logic [3:0]  upd_mask;
    logic        use_carry, add_sub_sel, flag_load;
    logic [3:0]  flag_wdata;
    logic        eval;
    logic [3:0]  cond_sel;
    logic        carry_in;
    logic [3:0]  flags;
    logic        branch_taken, branch_valid;
`ifdef ALU_FLAG_STICKY_OV_EN
    logic        sticky_clr;
    logic        sticky_ov;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    vec_t        vecs[$];
    exp_t        sb_q[$];

    always #5 clk = ~clk;

    alu_flag_register #(
        .DATA_W (16),
        .COND_W (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_z        (alu_z),
        .alu_cy       (alu_cy),
        .alu_ov       (alu_ov),
        .alu_valid    (alu_valid),
        .upd_mask     (upd_mask),
        .use_carry    (use_carry),
        .add_sub_sel  (add_sub_sel),
        .flag_load    (flag_load),
        .flag_wdata   (flag_wdata),
        .eval         (eval),
        .cond_sel     (cond_sel),
`ifdef ALU_FLAG_STICKY_OV_EN
        .sticky_clr   (sticky_clr),
        .sticky_ov    (sticky_ov),
`endif
        .carry_in     (carry_in),
        .flags        (flags),
        .branch_taken (branch_taken),
        .branch_valid (branch_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic rst, input logic [15:0] z, input logic cy, input logic ov,
                               input logic valid, input logic [3:0] mask, input logic uc, input logic sub,
                               input logic load, input logic [3:0] wdata, input logic ev, input logic [3:0] cond,
                               input logic cin, input logic [3:0] fl, input logic bv, input logic bt);
        vec_t r;
        r.rst = rst; r.z = z; r.cy = cy; r.ov = ov; r.valid = valid; r.mask = mask;
        r.uc = uc; r.sub = sub; r.load = load; r.wdata = wdata; r.ev = ev; r.cond = cond;
        r.exp_cin = cin; r.exp_flags = fl; r.exp_bv = bv; r.exp_bt = bt;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        reset = x.rst; alu_z = x.z; alu_cy = x.cy; alu_ov = x.ov; alu_valid = x.valid;
        upd_mask = x.mask; use_carry = x.uc; add_sub_sel = x.sub; flag_load = x.load;
        flag_wdata = x.wdata; eval = x.ev; cond_sel = x.cond;
    endtask

`ifdef ALU_FLAG_STICKY_OV_EN
    task automatic sticky_step(input string name, input logic clr, input logic valid, input logic ov,
                               input logic load, input logic [3:0] wdata, input logic exp_sticky);
        @(negedge clk);
        drive(v(0, 16'h0001, 0, ov, valid, 4'b1000, 0, 0, load, wdata, 0, 0, 0, 0, 0, 0));
        sticky_clr = clr;
        @(posedge clk);
        #1;
        check(name, {31'd0, sticky_ov}, {31'd0, exp_sticky});
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
`ifdef ALU_FLAG_STICKY_OV_EN
        sticky_clr = 1'b0;
`endif
        //          rst z         cy ov vl mask    uc sb ld wdata   ev cond        cin flags   bv bt
        vecs.push_back(v(1, 16'h0000, 0, 0, 0, 4'h0,    0, 0, 0, 4'b0000, 0, 4'd0,      0, 4'b0000, 0, 0));
        vecs.push_back(v(0, 16'h8000, 0, 1, 1, 4'hF,    0, 0, 0, 4'b0000, 0, 4'd0,      0, 4'b1100, 0, 0));
        vecs.push_back(v(0, 16'h0000, 0, 0, 0, 4'h0,    1, 0, 1, 4'b0010, 0, 4'd0,      0, 4'b0010, 0, 0));
        vecs.push_back(v(0, 16'h0000, 0, 0, 0, 4'h0,    1, 0, 0, 4'b0000, 0, 4'd0,      1, 4'b0010, 0, 0));
        vecs.push_back(v(0, 16'h0000, 0, 0, 0, 4'h0,    1, 1, 0, 4'b0000, 0, 4'd0,      0, 4'b0010, 0, 0));
        vecs.push_back(v(0, 16'h0000, 0, 0, 0, 4'h0,    0, 1, 0, 4'b0000, 0, 4'd0,      1, 4'b0010, 0, 0));
        vecs.push_back(v(0, 16'h0000, 0, 1, 1, 4'b0001, 0, 0, 0, 4'b0000, 0, 4'd0,      0, 4'b0011, 0, 0));
        vecs.push_back(v(0, 16'h0000, 1, 0, 1, 4'b0001, 0, 0, 1, 4'b0100, 0, 4'd0,      0, 4'b0100, 0, 0));
        vecs.push_back(v(0, 16'h0000, 1, 1, 0, 4'hF,    0, 0, 0, 4'b0000, 1, COND_PL,   0, 4'b0100, 1, 0));
        vecs.push_back(v(0, 16'h0000, 0, 0, 1, 4'b0001, 0, 0, 0, 4'b0000, 1, COND_EQ,   0, 4'b0101, 1, 1));
        vecs.push_back(v(0, 16'h0000, 0, 0, 0, 4'h0,    0, 0, 0, 4'b0000, 1, 4'd12,     0, 4'b0101, 1, 0));
        vecs.push_back(v(0, 16'h0005, 1, 0, 1, 4'hF,    0, 0, 0, 4'b0000, 1, COND_NE,   0, 4'b0010, 1, 1));
        vecs.push_back(v(0, 16'h0000, 0, 0, 0, 4'h0,    1, 1, 0, 4'b0000, 1, COND_CS,   0, 4'b0010, 1, 1));
        vecs.push_back(v(0, 16'h0000, 0, 0, 0, 4'h0,    0, 0, 0, 4'b0000, 1, COND_ALWAYS, 0, 4'b0010, 1, 1));
        vecs.push_back(v(0, 16'h0000, 0, 0, 0, 4'h0,    0, 0, 0, 4'b0000, 0, 4'd0,      0, 4'b0010, 0, 0));
        vecs.push_back(v(0, 16'h0000, 0, 0, 0, 4'h0,    0, 0, 0, 4'b0000, 1, COND_GE,   0, 4'b0010, 1, 1));
        vecs.push_back(v(0, 16'h0000, 0, 0, 0, 4'h0,    0, 0, 1, 4'b1000, 1, COND_LT,   0, 4'b1000, 1, 1));
        vecs.push_back(v(0, 16'h0000, 0, 0, 0, 4'h0,    0, 0, 0, 4'b0000, 1, COND_VS,   0, 4'b1000, 1, 1));
        vecs.push_back(v(0, 16'h0000, 0, 0, 0, 4'h0,    0, 0, 0, 4'b0000, 1, COND_VC,   0, 4'b1000, 1, 0));
        vecs.push_back(v(0, 16'h0000, 0, 0, 0, 4'h0,    0, 0, 0, 4'b0000, 1, COND_MI,   0, 4'b1000, 1, 0));
        vecs.push_back(v(0, 16'h0000, 0, 0, 0, 4'h0,    0, 0, 0, 4'b0000, 1, COND_CC,   0, 4'b1000, 1, 1));
        vecs.push_back(v(0, 16'h0000, 0, 0, 0, 4'h0,    0, 0, 0, 4'b0000, 1, 4'd15,     0, 4'b1000, 1, 0));
        vecs.push_back(v(1, 16'h0000, 0, 0, 0, 4'h0,    0, 0, 1, 4'b1111, 1, COND_EQ,   0, 4'b0000, 0, 0));
        vecs.push_back(v(0, 16'h0000, 0, 0, 0, 4'h0,    0, 0, 1, 4'b1111, 1, COND_NE,   0, 4'b1111, 1, 0));
        vecs.push_back(v(1, 16'h0000, 0, 0, 0, 4'h0,    0, 0, 0, 4'b0000, 1, COND_ALWAYS, 0, 4'b0000, 0, 0));
        vecs.push_back(v(0, 16'h0000, 0, 0, 0, 4'h0,    0, 0, 0, 4'b0000, 1, COND_ALWAYS, 0, 4'b0000, 1, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d carry_in", i), {31'd0, carry_in}, {31'd0, vecs[i].exp_cin});
            e.idx = i; e.flags = vecs[i].exp_flags; e.bv = vecs[i].exp_bv; e.bt = vecs[i].exp_bt;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            check($sformatf("v%0d flags", e.idx), {28'd0, flags}, {28'd0, e.flags});
            check($sformatf("v%0d branch_valid", e.idx), {31'd0, branch_valid}, {31'd0, e.bv});
            if (e.bv)
                check($sformatf("v%0d branch_taken", e.idx), {31'd0, branch_taken}, {31'd0, e.bt});
        end

`ifdef ALU_FLAG_STICKY_OV_EN
        @(negedge clk);
        drive(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("sticky reset", {31'd0, sticky_ov}, 32'd0);
        sticky_step("sticky alu set",        0, 1, 1, 0, 4'b0000, 1);
        sticky_step("sticky hold on ov0",    0, 1, 0, 0, 4'b0000, 1);
        sticky_step("sticky set beats clr",  1, 1, 1, 0, 4'b0000, 1);
        sticky_step("sticky clr",            1, 0, 0, 0, 4'b0000, 0);
        sticky_step("sticky load set",       0, 0, 0, 1, 4'b1000, 1);
        sticky_step("sticky load ov0 holds", 0, 0, 0, 1, 4'b0000, 1);
        sticky_step("sticky clr again",      1, 0, 0, 0, 4'b0000, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
